// File: rtl/fold_grp_issue.sv
// fold_grp_issue: buffers up to 4 decoded fold types/lengths and issues the longest legal fold group at the head
// Ports: clk, reset_l (async active-low), flush (drop all entries);
//   in_valid/in_ready/in_type/in_len push side; grp_valid/grp_ready/grp_cnt/grp_len/grp_types issue side.
// Macro FOLD_QUAD_EN enables the 4-wide LV LV OP MEM fold; when undefined the widest group is 3.
module fold_grp_issue #(
  parameter int DEPTH = 4,
  parameter int WAIT_MAX = 2
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_type,
  input  logic [2:0]  in_len,
  output logic        grp_valid,
  input  logic        grp_ready,
  output logic [2:0]  grp_cnt,
  output logic [4:0]  grp_len,
  output logic [23:0] grp_types
);
  localparam logic [5:0] NF = 6'd1, LV = 6'd2, OP = 6'd4, BG2 = 6'd8, BG1 = 6'd16, MEM = 6'd32;
  localparam int HW = $clog2(WAIT_MAX + 1);
`ifdef FOLD_QUAD_EN
  localparam bit QUAD = 1'b1;
`else
  localparam bit QUAD = 1'b0;
`endif
  typedef enum logic {EVAL, PRESENT} state_t;
  state_t state, state_nxt;
  logic [5:0] typ_q [DEPTH];
  logic [2:0] len_q [DEPTH];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count;
  logic [HW-1:0] hold_cnt;
  logic [5:0] t [4];
  logic [2:0] l [4];
  logic [5:0] in_san;
  logic push, pop, hold, latch, ext, m2, m3, m4;
  logic [2:0] best;
  logic [4:0] sum;
  logic [23:0] types;
  assign in_ready = count < 3'd4;
  assign push = in_valid & in_ready;
  assign in_san = (in_type != 6'd0 && (in_type & (in_type - 6'd1)) == 6'd0) ? in_type : NF;
  always_comb begin
    // Slots beyond count read as zero so they can never satisfy a pattern.
    for (int i = 0; i < 4; i++) begin
      t[i] = (3'(i) < count) ? typ_q[rd_ptr + 2'(i)] : 6'd0;
      l[i] = (3'(i) < count) ? len_q[rd_ptr + 2'(i)] : 3'd0;
    end
    m4 = QUAD && t[0] == LV && t[1] == LV && t[2] == OP && t[3] == MEM;
    m3 = (t[0] == LV && t[1] == LV && (t[2] == OP || t[2] == BG2)) || (t[0] == LV && t[1] == OP && t[2] == MEM);
    m2 = (t[0] == LV && (t[1] == OP || t[1] == BG1 || t[1] == BG2 || t[1] == MEM)) || (t[0] == OP && t[1] == MEM);
    best = m4 ? 3'd4 : m3 ? 3'd3 : m2 ? 3'd2 : 3'd1;
    // Present entries are a strict prefix of some longer pattern; a full FIFO can never grow.
    ext = (count == 3'd1 && (t[0] == LV || t[0] == OP))
       || (count == 3'd2 && t[0] == LV && (t[1] == LV || t[1] == OP))
       || (QUAD && count == 3'd3 && t[0] == LV && t[1] == LV && t[2] == OP);
    sum = 5'd0;
    types = 24'd0;
    for (int i = 0; i < 4; i++) begin
      sum = sum + ((3'(i) < best) ? 5'(l[i]) : 5'd0);
      types[6*i +: 6] = (3'(i) < best) ? t[i] : 6'd0;
    end
    hold = state == EVAL && count != 3'd0 && ext && hold_cnt < HW'(WAIT_MAX);
    latch = state == EVAL && count != 3'd0 && !hold;
    pop = state == PRESENT && grp_ready;
    state_nxt = flush ? EVAL : latch ? PRESENT : pop ? EVAL : state;
  end
  always_ff @(posedge clk)
    if (push && !flush) begin
      typ_q[wr_ptr] <= in_san;
      len_q[wr_ptr] <= in_len;
    end
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      state <= EVAL;
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count <= 3'd0;
      hold_cnt <= '0;
      grp_valid <= 1'b0;
      grp_cnt <= 3'd0;
      grp_len <= 5'd0;
      grp_types <= 24'd0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        rd_ptr <= 2'd0;
        wr_ptr <= 2'd0;
        count <= 3'd0;
        hold_cnt <= '0;
        grp_valid <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 2'd1;
        if (pop) rd_ptr <= rd_ptr + grp_cnt[1:0];
        count <= count + 3'(push) - (pop ? grp_cnt : 3'd0);
        // A fresh arrival restarts the wait so a back-to-back burst can complete the full fold.
        hold_cnt <= pop ? '0 : hold ? (push ? '0 : hold_cnt + 1'b1) : hold_cnt;
        grp_valid <= latch | (grp_valid & !pop);
        if (latch) begin
          grp_cnt <= best;
          grp_len <= sum;
          grp_types <= types;
        end
      end
    end
endmodule
